sm_conv_sched: RTL and testbench

Round-robin scheduler that shares one registered two's-complement to sign-magnitude conversion stage between NCH filter channels (e.g. per-wheel encoder/speed paths).
- Arbitrates requests and captures the winning channel's sample.
- Converts it and presents magnitude, sign and channel tag to the downstream consumer under a valid/ready handshake.
- Sits between the per-channel filter front-ends and the shared magnitude-domain processing.

---
 rtl/sm_conv_sched_if.sv | 44 ++++
 rtl/sm_conv_sched.sv | 187 ++++++++++++++++++
 tb/tb_sm_conv_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_conv_sched_if.sv
// ---------------------------------------------------------------------------
// sm_conv_sched_if
// Bundles the request side (per-channel req / enable / samples / ack) and the
// result side (valid/ready handshake with magnitude, sign and channel tag) of
// the shared sign-magnitude conversion scheduler.
//
//   req       [NCH]     per-channel conversion request (level)
//   ch_en     [NCH]     per-channel enable mask
//   data_in   [NCH*DW]  flat sample bus, channel i at [i*DW +: DW]
//   ack       [NCH]     one-hot capture pulse
//   res_valid / res_ready   result handshake
//   res_mag   [DW]      magnitude, unsigned
//   res_sign            1 = sample was negative
//   res_ch    [CW]      channel tag of the result
//   busy                scheduler is not idle
//
// master: requesters + downstream consumer.  slave: the scheduler.
// ---------------------------------------------------------------------------
interface sm_conv_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int CW  = 2
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    ack;
  logic              res_valid;
  logic              res_ready;
  logic [DW-1:0]     res_mag;
  logic              res_sign;
  logic [CW-1:0]     res_ch;
  logic              busy;

  modport master (
    output req, ch_en, data_in, res_ready,
    input  ack, res_valid, res_mag, res_sign, res_ch, busy
  );

  modport slave (
    input  req, ch_en, data_in, res_ready,
    output ack, res_valid, res_mag, res_sign, res_ch, busy
  );
endinterface

// File: rtl/sm_conv_sched.sv
// ---------------------------------------------------------------------------
// sm_conv_sched
// Round-robin scheduler sharing one registered two's-complement to
// sign-magnitude conversion stage between NCH filter channels.
//
// IDLE samples req & ch_en, grants the first eligible channel after the last
// grant (mod NCH), captures its sample and pulses ack for one cycle. CONV
// converts the captured sample. HOLD presents the result until res_ready.
// Peak throughput is one conversion per three cycles.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   io_bus  sm_conv_sched_if.slave (request, ack and result handshake)
// ---------------------------------------------------------------------------
module sm_conv_sched #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sm_conv_sched_if.slave io_bus
);

  // Channel indices are CW bits wide; the eligibility vector and the sample
  // array are padded to 2**CW entries so a CW-bit index is always in range.
  localparam int unsigned NSLOT = 1 << CW;
  localparam int unsigned NCH_U = NCH;

  if ((NCH < 2) || (NCH > 8) || (NSLOT < NCH_U)) begin : g_bad_param
    $error("sm_conv_sched: NCH must be 2..8 and 2**CW >= NCH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_last_grant;
  logic [CW-1:0]   w_last_grant_nxt;
  logic [CW-1:0]   r_sel_ch;
  logic [CW-1:0]   w_sel_ch_nxt;
  logic [DW-1:0]   r_sel_data;
  logic [DW-1:0]   w_sel_data_nxt;

  logic [NCH-1:0]  r_ack;
  logic [NCH-1:0]  w_ack_nxt;
  logic            r_res_valid;
  logic            w_res_valid_nxt;
  logic [DW-1:0]   r_res_mag;
  logic [DW-1:0]   w_res_mag_nxt;
  logic            r_res_sign;
  logic            w_res_sign_nxt;
  logic [CW-1:0]   r_res_ch;
  logic [CW-1:0]   w_res_ch_nxt;

  logic [NSLOT-1:0] w_elig;
  logic [DW-1:0]    w_sample [NSLOT];
  logic             w_grant_vld;
  logic [CW-1:0]    w_grant_ch;

  // -------------------------------------------------------------------------
  // Request qualification and sample demux
  // -------------------------------------------------------------------------
  assign w_elig = NSLOT'(io_bus.req & io_bus.ch_en);

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi < NCH) begin : g_used
      assign w_sample[gi] = io_bus.data_in[gi*DW +: DW];
    end else begin : g_pad
      assign w_sample[gi] = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first eligible channel scanning last_grant+1,
  // last_grant+2, ... modulo NCH. The previous winner is scanned last, so it
  // only wins again when nobody else is eligible.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [CW-1:0] cand;
    cand        = '0;
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    for (int unsigned k = 1; k <= NCH_U; k++) begin
      cand = CW'((32'(r_last_grant) + k) % NCH_U);
      if (!w_grant_vld && w_elig[cand]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_sel_ch_nxt     = r_sel_ch;
    w_sel_data_nxt   = r_sel_data;
    w_ack_nxt        = '0;
    w_res_valid_nxt  = r_res_valid;
    w_res_mag_nxt    = r_res_mag;
    w_res_sign_nxt   = r_res_sign;
    w_res_ch_nxt     = r_res_ch;

    unique case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_sel_ch_nxt     = w_grant_ch;
          w_sel_data_nxt   = w_sample[w_grant_ch];
          w_last_grant_nxt = w_grant_ch;
          w_ack_nxt        = NCH'(1'b1) << w_grant_ch;
          w_state_nxt      = S_CONV;
        end
      end

      S_CONV: begin
        // Negation wraps for the most-negative code: its magnitude reads
        // correctly as an unsigned DW-bit value, so no saturation is needed.
        if (r_sel_data[DW-1]) begin
          w_res_mag_nxt  = (~r_sel_data) + DW'(1);
          w_res_sign_nxt = 1'b1;
        end else begin
          w_res_mag_nxt  = r_sel_data;
          w_res_sign_nxt = 1'b0;
        end
        w_res_ch_nxt    = r_sel_ch;
        w_res_valid_nxt = 1'b1;
        w_state_nxt     = S_HOLD;
      end

      S_HOLD: begin
        if (io_bus.res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_res_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= CW'(NCH - 1);
      r_sel_ch     <= '0;
      r_sel_data   <= '0;
      r_ack        <= '0;
      r_res_valid  <= 1'b0;
      r_res_mag    <= '0;
      r_res_sign   <= 1'b0;
      r_res_ch     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_sel_ch     <= w_sel_ch_nxt;
      r_sel_data   <= w_sel_data_nxt;
      r_ack        <= w_ack_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_res_mag    <= w_res_mag_nxt;
      r_res_sign   <= w_res_sign_nxt;
      r_res_ch     <= w_res_ch_nxt;
    end
  end

  assign io_bus.ack       = r_ack;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_mag   = r_res_mag;
  assign io_bus.res_sign  = r_res_sign;
  assign io_bus.res_ch    = r_res_ch;
  assign io_bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sm_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_sm_conv_sched
// Randomised requesters drive sm_conv_sched. Each requester pushes the
// expected sign-magnitude result of its sample into a per-channel queue when
// it raises a request. A separate monitor predicts grants from the
// round-robin rule, moves the granted channel's expectation into the result
// queue and compares the DUT outputs against it every cycle.
// ---------------------------------------------------------------------------
module tb_sm_conv_sched;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sm_conv_sched_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus ();

  sm_conv_sched #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] mag;
    logic          sign;
    logic [CW-1:0] ch;
  } exp_t;

  exp_t chq [NCH][$];
  exp_t rq [$];

  int errors = 0;
  int checks = 0;

  // stimulus knobs
  int             raise_pct = 0;
  int             keep_pct  = 0;
  int             drop_pct  = 0;
  int             ready_pct = 100;
  int             en_pct    = 0;
  logic [NCH-1:0] raise_mask = '0;
  logic           fixed_en   = 1'b0;
  logic [DW-1:0]  fixed_vals [NCH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion: plain signed arithmetic on the sample value.
  function automatic exp_t make_exp(input int ch, input logic [DW-1:0] d);
    exp_t e;
    int   v;
    v      = int'(signed'(d));
    e.sign = (v < 0);
    e.mag  = DW'((v < 0) ? -v : v);
    e.ch   = CW'(ch);
    return e;
  endfunction

  // Round-robin reference: eligible channel at the smallest forward distance
  // from the previous winner (the previous winner itself is furthest).
  function automatic int rr_pick(input logic [NCH-1:0] el, input int last);
    int best  = -1;
    int bestd = NCH + 1;
    for (int c = 0; c < NCH; c++) begin
      if (el[c]) begin
        int d;
        d = (c - last - 1 + 2*NCH) % NCH;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [DW-1:0] pick_data(input int ch);
    int unsigned r;
    if (fixed_en) return fixed_vals[ch];
    r = $urandom_range(0, 7);
    case (r)
      0: return 16'h8000;
      1: return 16'h0000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  // One requester/consumer update, called just after a rising edge.
  task automatic step_requesters();
    logic [NCH-1:0] a;
    logic [DW-1:0]  d;
    a = bus.ack;
    for (int i = 0; i < NCH; i++) begin
      if (a[i]) begin
        if (raise_mask[i] && ($urandom_range(0, 99) < keep_pct)) begin
          d = pick_data(i);
          bus.data_in[i*DW +: DW] = d;
          chq[i].push_back(make_exp(i, d));
        end else begin
          bus.req[i] = 1'b0;
        end
      end else if (bus.req[i]) begin
        if ($urandom_range(0, 99) < drop_pct) begin
          bus.req[i] = 1'b0;
          void'(chq[i].pop_back());
        end
      end else if (raise_mask[i] && ($urandom_range(0, 99) < raise_pct)) begin
        d = pick_data(i);
        bus.data_in[i*DW +: DW] = d;
        bus.req[i] = 1'b1;
        chq[i].push_back(make_exp(i, d));
      end
      if ((en_pct > 0) && ($urandom_range(0, 99) < en_pct))
        bus.ch_en[i] = ~bus.ch_en[i];
    end
    bus.res_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step_requesters();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},   64'(bus.ack),       64'h0);
    chk({tag, "_valid"}, 64'(bus.res_valid), 64'h0);
    chk({tag, "_busy"},  64'(bus.busy),      64'h0);
    chk({tag, "_mag"},   64'(bus.res_mag),   64'h0);
    chk({tag, "_sign"},  64'(bus.res_sign),  64'h0);
    chk({tag, "_ch"},    64'(bus.res_ch),    64'h0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  initial begin
    int             phase;      // 0 idle, 1 capture cycle, 2 result held
    int             lastg;
    int             g;
    logic [NCH-1:0] elig_prev;
    logic           ready_prev;
    logic [NCH-1:0] exp_ack;
    phase      = 0;
    lastg      = NCH - 1;
    elig_prev  = '0;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase      = 0;
        lastg      = NCH - 1;
        elig_prev  = '0;
        ready_prev = 1'b0;
        rq.delete();
        continue;
      end
      exp_ack = '0;
      case (phase)
        0: if (elig_prev != '0) begin
             g       = rr_pick(elig_prev, lastg);
             lastg   = g;
             exp_ack = NCH'(1) << g;
             phase   = 1;
             if (chq[g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_source: channel %0d granted with no pending sample", g);
             end else begin
               rq.push_back(chq[g].pop_front());
             end
           end
        1: phase = 2;
        default: if (ready_prev) phase = 0;
      endcase
      chk("ack",       64'(bus.ack),       64'(exp_ack));
      chk("busy",      64'(bus.busy),      64'(phase != 0));
      chk("res_valid", 64'(bus.res_valid), 64'(phase == 2));
      if (phase == 2 && rq.size() > 0)
        chk("result{mag,sign,ch}", 64'({bus.res_mag, bus.res_sign, bus.res_ch}), 64'(rq[0]));
      elig_prev  = bus.req & bus.ch_en;
      ready_prev = bus.res_ready;
      if (phase == 2 && ready_prev && rq.size() > 0)
        void'(rq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    bit found;
    bus.req       = '0;
    bus.ch_en     = '1;
    bus.data_in   = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < NCH; i++) fixed_vals[i] = '0;

    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single negative request on channel 0
    fixed_en = 1'b1; fixed_vals[0] = 16'hFFFB;
    raise_mask = 4'b0001; raise_pct = 100; keep_pct = 0; ready_pct = 100;
    run(8);

    // all channels continuously, boundary samples, full-rate acceptance
    fixed_vals[0] = 16'h0010; fixed_vals[1] = 16'hFFF0;
    fixed_vals[2] = 16'h7FFF; fixed_vals[3] = 16'h8000;
    raise_mask = 4'b1111; keep_pct = 100;
    run(40);

    // backpressure with random samples
    fixed_en = 1'b0; ready_pct = 20; keep_pct = 60; raise_pct = 40;
    run(200);

    // masking: channel 1 requests but is disabled
    raise_mask = 4'b0110; keep_pct = 100; raise_pct = 100; ready_pct = 100;
    bus.ch_en = 4'b0100;
    run(30);
    bus.ch_en = 4'b0110;
    run(30);

    // drain
    bus.ch_en = '1; raise_mask = '0;
    run(20);

    // reset while the capture cycle is in progress
    raise_mask = 4'b0010; raise_pct = 100; keep_pct = 100;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk);
      #1;
      if (bus.ack != '0) begin
        found = 1'b1;
        rst_n = 1'b0;
        #1 chk_reset_outputs("midconv");
        bus.req = '0;
        for (int i = 0; i < NCH; i++) chq[i].delete();
      end else begin
        step_requesters();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_wait: no ack within 20 cycles, got 0 expected 1");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    raise_mask = 4'b1110; raise_pct = 100; keep_pct = 100;
    run(30);

    // drain, then zero sample on channel 3 against channel 0
    raise_mask = '0;
    run(20);
    fixed_en = 1'b1; fixed_vals[0] = 16'h1234; fixed_vals[3] = 16'h0000;
    raise_mask = 4'b0001; raise_pct = 100; keep_pct = 0;
    run(6);
    raise_mask = 4'b1001; keep_pct = 100;
    run(20);

    // random soak: drops, enable toggles, random ready
    fixed_en = 1'b0; raise_pct = 30; keep_pct = 50; drop_pct = 5;
    ready_pct = 60; en_pct = 5; raise_mask = '1;
    run(1500);

    // final drain
    en_pct = 0; drop_pct = 0; raise_mask = '0; ready_pct = 100;
    bus.ch_en = '1;
    run(30);
    chk("drain_results", 64'(rq.size()), 64'h0);
    for (int i = 0; i < NCH; i++)
      chk("drain_pending", 64'(chq[i].size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
